rgb_to_ycbcr: RTL and testbench

Streaming pixel-colour-space converter. Takes 8-bit R/G/B pixels with camera-style vsync/href framing and produces 8-bit Y/Cb/Cr per BT.601 full-range integer approximation. Sits in the video pipeline between the pixel source (sensor/DMA) and downstream YCbCr processing. Framing signals are delayed to stay aligned with the data; one pixel per clock, no back-pressure.

---
 rtl/rgb_to_ycbcr.sv | 78 +++++++
 tb/tb_rgb_to_ycbcr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_ycbcr.sv
// Streaming RGB888 -> YCbCr888 (BT.601 full range), 3-stage pipeline with aligned vsync/href.
// Define RGB_TO_YCBCR_ROUND_EN for round-to-nearest with saturation; default build truncates.
module rgb_to_ycbcr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic [7:0] post_img_Y,
  output logic [7:0] post_img_Cb,
  output logic [7:0] post_img_Cr
);

`ifdef RGB_TO_YCBCR_ROUND_EN
  localparam logic [16:0] BIAS = 17'd128;
`else
  localparam logic [16:0] BIAS = 17'd0;
`endif
  localparam logic [16:0] OFFSET = 17'd32768;

  logic [15:0] r_y, g_y, b_y, r_cb, g_cb, b_cb, r_cr, g_cr, b_cr;
  logic [16:0] y_sum, cb_sum, cr_sum;
  logic [16:0] y_nxt, cb_nxt, cr_nxt;
  logic [2:0]  vsync_pipe, href_pipe;

  // Chroma kept non-negative: offset and positive term are added before the
  // negative products are removed, so the 17-bit result never wraps.
  always_comb begin
    y_nxt  = {1'b0, r_y} + {1'b0, g_y} + {1'b0, b_y} + BIAS;
    cb_nxt = OFFSET + {1'b0, b_cb} + BIAS - {1'b0, r_cb} - {1'b0, g_cb};
    cr_nxt = OFFSET + {1'b0, r_cr} + BIAS - {1'b0, g_cr} - {1'b0, b_cr};
  end

  // Bit 16 can only be set by the rounding bias; clamp to full scale.
  function automatic logic [7:0] clip(input logic [16:0] s);
    return s[16] ? 8'hFF : s[15:8];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y  <= '0; g_y  <= '0; b_y  <= '0;
      r_cb <= '0; g_cb <= '0; b_cb <= '0;
      r_cr <= '0; g_cr <= '0; b_cr <= '0;
      y_sum <= '0; cb_sum <= '0; cr_sum <= '0;
      post_img_Y  <= '0;
      post_img_Cb <= '0;
      post_img_Cr <= '0;
      vsync_pipe  <= '0;
      href_pipe   <= '0;
    end else begin
      r_y  <= 16'd77  * {8'd0, per_img_red};
      g_y  <= 16'd150 * {8'd0, per_img_green};
      b_y  <= 16'd29  * {8'd0, per_img_blue};
      r_cb <= 16'd43  * {8'd0, per_img_red};
      g_cb <= 16'd85  * {8'd0, per_img_green};
      b_cb <= 16'd128 * {8'd0, per_img_blue};
      r_cr <= 16'd128 * {8'd0, per_img_red};
      g_cr <= 16'd107 * {8'd0, per_img_green};
      b_cr <= 16'd21  * {8'd0, per_img_blue};
      y_sum  <= y_nxt;
      cb_sum <= cb_nxt;
      cr_sum <= cr_nxt;
      post_img_Y  <= href_pipe[1] ? clip(y_sum)  : 8'd0;
      post_img_Cb <= href_pipe[1] ? clip(cb_sum) : 8'd0;
      post_img_Cr <= href_pipe[1] ? clip(cr_sum) : 8'd0;
      vsync_pipe  <= {vsync_pipe[1:0], per_img_vsync};
      href_pipe   <= {href_pipe[1:0], per_img_href};
    end
  end

  assign post_img_vsync = vsync_pipe[2];
  assign post_img_href  = href_pipe[2];

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Scoreboard bench for rgb_to_ycbcr: expected pixels queued at sampling, checked by a negedge monitor.
module tb_rgb_to_ycbcr;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0, href = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic       post_vsync, post_href;
  logic [7:0] y, cb, cr;

  typedef struct packed { logic [7:0] y, cb, cr; } pix_t;

  pix_t       exp_in = '0;
  pix_t       sb[$];
  logic [2:0] vs_pipe = '0, hr_pipe = '0;
  int n_checks = 0, n_fail = 0;
  int n_pushed = 0, n_popped = 0, n_flushed = 0;

  rgb_to_ycbcr dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(vsync), .per_img_href(href),
    .per_img_red(red), .per_img_green(green), .per_img_blue(blue),
    .post_img_vsync(post_vsync), .post_img_href(post_href),
    .post_img_Y(y), .post_img_Cb(cb), .post_img_Cr(cr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pix_t golden(input int r, input int g, input int b);
    int ys, cbs, crs, rnd;
    pix_t p;
`ifdef RGB_TO_YCBCR_ROUND_EN
    rnd = 128;
`else
    rnd = 0;
`endif
    ys  = (77 * r + 150 * g + 29 * b + rnd) >>> 8;
    cbs = (-43 * r - 85 * g + 128 * b + 32768 + rnd) >>> 8;
    crs = (128 * r - 107 * g - 21 * b + 32768 + rnd) >>> 8;
    p.y  = (ys  > 255) ? 8'd255 : ys[7:0];
    p.cb = (cbs > 255) ? 8'd255 : cbs[7:0];
    p.cr = (crs > 255) ? 8'd255 : crs[7:0];
    return p;
  endfunction

  // Sampler: models the 3-flop framing delay and enqueues expected pixels.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      vs_pipe = '0;
      hr_pipe = '0;
      n_flushed = n_flushed + sb.size();
      sb.delete();
    end else begin
      vs_pipe = {vs_pipe[1:0], vsync};
      hr_pipe = {hr_pipe[1:0], href};
      if (href) begin
        sb.push_back(exp_in);
        n_pushed++;
      end
    end
  end

  // Monitor
  initial forever begin
    pix_t p;
    @(negedge clk);
    check("vsync", int'(post_vsync), int'(vs_pipe[2]));
    check("href", int'(post_href), int'(hr_pipe[2]));
    if (post_href === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pixel: got Y=%0d Cb=%0d Cr=%0d expected none", y, cb, cr);
      end else begin
        p = sb.pop_front();
        n_popped++;
        check("Y", int'(y), int'(p.y));
        check("Cb", int'(cb), int'(p.cb));
        check("Cr", int'(cr), int'(p.cr));
      end
    end else begin
      check("Y_idle", int'(y), 0);
      check("Cb_idle", int'(cb), 0);
      check("Cr_idle", int'(cr), 0);
    end
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] r, g, b, input pix_t e);
    vsync = v; href = h; red = r; green = g; blue = b; exp_in = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic v, input int n);
    for (int i = 0; i < n; i++) drive(v, 1'b0, 8'd0, 8'd0, 8'd0, '0);
  endtask

  task automatic rand_pix(input logic v);
    logic [7:0] r, g, b;
    r = 8'($urandom_range(0, 255));
    g = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    drive(v, 1'b1, r, g, b, golden(int'(r), int'(g), int'(b)));
  endtask

  localparam int NV = 7;
  logic [7:0] tr[NV] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd100, 8'd10};
  logic [7:0] tg[NV] = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd150, 8'd20};
  logic [7:0] tb[NV] = '{8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd200, 8'd30};
`ifdef RGB_TO_YCBCR_ROUND_EN
  pix_t te[NV] = '{'{8'd255, 8'd128, 8'd128}, '{8'd0, 8'd128, 8'd128}, '{8'd77, 8'd85, 8'd255},
                   '{8'd29, 8'd255, 8'd107}, '{8'd149, 8'd43, 8'd21}, '{8'd141, 8'd161, 8'd99},
                   '{8'd18, 8'd135, 8'd122}};
`else
  pix_t te[NV] = '{'{8'd255, 8'd128, 8'd128}, '{8'd0, 8'd128, 8'd128}, '{8'd76, 8'd85, 8'd255},
                   '{8'd28, 8'd255, 8'd107}, '{8'd149, 8'd43, 8'd21}, '{8'd140, 8'd161, 8'd98},
                   '{8'd18, 8'd134, 8'd122}};
`endif

  initial begin
    int base;
    // Reset held with random inputs: outputs must stay 0.
    rst_n = 1'b0;
    for (int i = 0; i < 50; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            8'($urandom), '0);
    rst_n = 1'b1;
    idle(1'b0, 4);

    // Directed vectors with gaps, then back-to-back.
    idle(1'b1, 2);
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, 1'b1, tr[i], tg[i], tb[i], te[i]);
      idle(1'b1, 1);
    end
    for (int i = 0; i < NV; i++) drive(1'b1, 1'b1, tr[i], tg[i], tb[i], te[i]);
    idle(1'b1, 4);

    // Single-cycle href pulse, then vsync fall.
    drive(1'b1, 1'b1, tr[5], tg[5], tb[5], te[5]);
    idle(1'b1, 4);
    idle(1'b0, 5);

    // Small random frame: lines 0/1 with zero blanking, others with gaps.
    base = n_popped;
    idle(1'b0, 5);
    idle(1'b1, 5);
    for (int row = 0; row < 6; row++) begin
      for (int col = 0; col < 16; col++) rand_pix(1'b1);
      if (row != 0) idle(1'b1, 3);
    end
    idle(1'b0, 5);
    check("frame_pixels", n_popped - base, 96);

    // href while vsync low is still converted.
    for (int i = 0; i < 4; i++) rand_pix(1'b0);
    idle(1'b0, 4);

    // Reset for one cycle mid-line discards in-flight pixels.
    idle(1'b1, 2);
    for (int i = 0; i < 3; i++) rand_pix(1'b1);
    rst_n = 1'b0;
    rand_pix(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) rand_pix(1'b1);
    idle(1'b1, 4);
    idle(1'b0, 4);

    check("queue_empty", sb.size(), 0);
    check("pixel_balance", n_popped, n_pushed - n_flushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
